// File: rtl/lag_servo_pkg.sv
// Shared types, constants and helpers for the lag-to-servo duty scheduler.
package lag_servo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC0,
        ST_CALC1,
        ST_CALC2,
        ST_COMMIT
    } state_e;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned LAG_FIELD_W = 12;
    localparam int unsigned LAG_BUS_W   = NUM_CH * LAG_FIELD_W;

    // Saturate x into [lo, hi]; callers sign-extend narrower values to 32 bits.
    function automatic logic signed [31:0] sat_clamp(
        input logic signed [31:0] x,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/lag_servo_scheduler_step.sv
// Shared slew unit: moves a shadow duty toward its target by at most STEP_MAX.
module servo_slew_step
    import lag_servo_pkg::*;
#(
    parameter int unsigned DUTY_W   = 16,
    parameter int unsigned STEP_MAX = 500
) (
    input  logic [DUTY_W-1:0] target_i,
    input  logic [DUTY_W-1:0] shadow_i,
    output logic [DUTY_W-1:0] next_shadow_c
);

    localparam int unsigned       IW       = DUTY_W + 2;
    localparam logic signed [31:0] STEP_LIM = 32'(STEP_MAX);

    logic signed [IW-1:0] target_s;
    logic signed [IW-1:0] shadow_s;
    logic signed [IW-1:0] delta;
    logic signed [IW-1:0] delta_lim;
    logic signed [IW-1:0] sum;

    always_comb begin
        target_s      = $signed(IW'(target_i));
        shadow_s      = $signed(IW'(shadow_i));
        delta         = target_s - shadow_s;
        delta_lim     = IW'(sat_clamp(32'(delta), -STEP_LIM, STEP_LIM));
        sum           = shadow_s + delta_lim;
        next_shadow_c = DUTY_W'(sum);
    end

endmodule

// File: rtl/lag_servo_scheduler.sv
// Turns lag triplets into three servo duties, slewed once per PWM frame through one shared step unit.
// The default duty values exceed 16 bits; instantiate with DUTY_W >= 17 for that range.
module lag_servo_scheduler
    import lag_servo_pkg::*;
#(
    parameter int unsigned LAG_W           = LAG_FIELD_W,
    parameter int unsigned DUTY_W          = 16,
    parameter int unsigned PERIOD          = 1000000,
    parameter int unsigned DUTY_CENTER     = 75000,
    parameter int unsigned DUTY_MIN        = 50000,
    parameter int unsigned DUTY_MAX        = 100000,
    parameter int unsigned GAIN_SHL        = 4,
    parameter int unsigned STEP_MAX        = 500,
    parameter int unsigned TIMEOUT_PERIODS = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*LAG_W-1:0]   lags_in,
    input  logic                      lags_in_valid,
    output logic [DUTY_W-1:0]         duty_0,
    output logic [DUTY_W-1:0]         duty_1,
    output logic [DUTY_W-1:0]         duty_2,
    output logic                      duty_load,
    output logic                      period_tick,
    output logic                      busy,
    output logic                      stale
);

    localparam int unsigned IW    = DUTY_W + 2;
    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_PERIODS + 1);

    localparam logic [CNT_W-1:0]        PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]         TO_MAX      = TO_W'(TIMEOUT_PERIODS);
    localparam logic signed [IW-1:0]    CENTER_S    = IW'(DUTY_CENTER);
    localparam logic [DUTY_W-1:0]       CENTER_D    = DUTY_W'(DUTY_CENTER);

    typedef logic [NUM_CH-1:0][DUTY_W-1:0] duty_arr_t;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          frame_q, frame_d;
    logic                      tick_q, tick_d;
    logic [TO_W-1:0]           to_q, to_d;
    logic                      seen_q, seen_d;
    logic                      stale_q, stale_d;
    logic                      pending_q, pending_d;
    logic [NUM_CH*LAG_W-1:0]   lags_q, lags_d;
    logic [NUM_CH*LAG_W-1:0]   lags_use_c;
    duty_arr_t                 target_q, target_d;
    duty_arr_t                 shadow_q, shadow_d;
    duty_arr_t                 duty_q, duty_d;
    logic                      load_q, load_d;
    logic                      busy_q, busy_d;
    logic [DUTY_W-1:0]         step_target_c;
    logic [DUTY_W-1:0]         step_shadow_c;
    logic [DUTY_W-1:0]         step_next_c;

    function automatic logic [DUTY_W-1:0] lag_to_target(input logic [LAG_W-1:0] lag);
        logic signed [IW-1:0] ext;
        logic signed [IW-1:0] raw;
        ext = IW'($signed(lag));
        raw = CENTER_S + (ext <<< GAIN_SHL);
        return DUTY_W'(sat_clamp(32'(raw), 32'(DUTY_MIN), 32'(DUTY_MAX)));
    endfunction

    servo_slew_step #(
        .DUTY_W   (DUTY_W),
        .STEP_MAX (STEP_MAX)
    ) u_step (
        .target_i      (step_target_c),
        .shadow_i      (step_shadow_c),
        .next_shadow_c (step_next_c)
    );

    // Frame timebase and lag-update watchdog.
    always_comb begin
        frame_d = (frame_q == PERIOD_LAST) ? '0 : frame_q + CNT_W'(1);
        tick_d  = (frame_d == PERIOD_LAST);
        seen_d  = seen_q;
        to_d    = to_q;
        if (lags_in_valid) begin
            seen_d = 1'b1;
            to_d   = '0;
        end
        if (tick_q) begin
            seen_d = 1'b0;
            if (!lags_in_valid && !seen_q && to_q != TO_MAX) begin
                to_d = to_q + TO_W'(1);
            end
        end
        stale_d = (to_d == TO_MAX);
    end

    always_comb begin
        step_target_c = target_q[0];
        step_shadow_c = shadow_q[0];
        unique case (state_q)
            ST_CALC1: begin
                step_target_c = target_q[1];
                step_shadow_c = shadow_q[1];
            end
            ST_CALC2: begin
                step_target_c = target_q[2];
                step_shadow_c = shadow_q[2];
            end
            default: ;
        endcase
    end

    // A valid arriving in LOAD is used directly so it is consumed that cycle.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        shadow_d   = shadow_q;
        duty_d     = duty_q;
        load_d     = 1'b0;
        pending_d  = pending_q;
        lags_d     = lags_q;
        lags_use_c = lags_in_valid ? lags_in : lags_q;
        if (lags_in_valid) begin
            pending_d = 1'b1;
            lags_d    = lags_in;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (tick_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (stale_q && !lags_in_valid) begin
                    target_d = {NUM_CH{CENTER_D}};
                end else if (pending_q || lags_in_valid) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        target_d[ch] = lag_to_target(lags_use_c[ch*LAG_W +: LAG_W]);
                    end
                    pending_d = 1'b0;
                end
                state_d = ST_CALC0;
            end
            ST_CALC0: begin
                shadow_d[0] = step_next_c;
                state_d     = ST_CALC1;
            end
            ST_CALC1: begin
                shadow_d[1] = step_next_c;
                state_d     = ST_CALC2;
            end
            ST_CALC2: begin
                shadow_d[2] = step_next_c;
                duty_d[0]   = shadow_q[0];
                duty_d[1]   = shadow_q[1];
                duty_d[2]   = step_next_c;
                load_d      = 1'b1;
                state_d     = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            tick_q    <= 1'b0;
            to_q      <= '0;
            seen_q    <= 1'b0;
            stale_q   <= 1'b0;
            pending_q <= 1'b0;
            lags_q    <= '0;
            target_q  <= {NUM_CH{CENTER_D}};
            shadow_q  <= {NUM_CH{CENTER_D}};
            duty_q    <= {NUM_CH{CENTER_D}};
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            tick_q    <= tick_d;
            to_q      <= to_d;
            seen_q    <= seen_d;
            stale_q   <= stale_d;
            pending_q <= pending_d;
            lags_q    <= lags_d;
            target_q  <= target_d;
            shadow_q  <= shadow_d;
            duty_q    <= duty_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
        end
    end

    assign duty_0      = duty_q[0];
    assign duty_1      = duty_q[1];
    assign duty_2      = duty_q[2];
    assign duty_load   = load_q;
    assign period_tick = tick_q;
    assign busy        = busy_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_lag_servo_scheduler.sv
// Directed bench for lag_servo_scheduler: table of per-frame commits plus latency, clamp, timeout and reset sequences.
module tb_lag_servo_scheduler;

    localparam int unsigned LAG_W  = 12;
    localparam int unsigned DUTY_W = 17;
    localparam int unsigned PERIOD = 16;

    logic                 clk;
    logic                 reset;
    logic [3*LAG_W-1:0]   lags_in;
    logic                 lags_in_valid;
    logic [DUTY_W-1:0]    duty_0, duty_1, duty_2;
    logic                 duty_load, period_tick, busy, stale;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit send;
        int l0, l1, l2;
        int e0, e1, e2;
    } vec_t;

    vec_t vecs [10];

    lag_servo_scheduler #(
        .LAG_W           (LAG_W),
        .DUTY_W          (DUTY_W),
        .PERIOD          (PERIOD),
        .DUTY_CENTER     (75000),
        .DUTY_MIN        (50000),
        .DUTY_MAX        (100000),
        .GAIN_SHL        (4),
        .STEP_MAX        (500),
        .TIMEOUT_PERIODS (50)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lags_in       (lags_in),
        .lags_in_valid (lags_in_valid),
        .duty_0        (duty_0),
        .duty_1        (duty_1),
        .duty_2        (duty_2),
        .duty_load     (duty_load),
        .period_tick   (period_tick),
        .busy          (busy),
        .stale         (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; holds the valid for one cycle and returns at the next negedge.
    task automatic send(input int l0, input int l1, input int l2);
        lags_in       = {LAG_W'(l2), LAG_W'(l1), LAG_W'(l0)};
        lags_in_valid = 1'b1;
        @(negedge clk);
        lags_in_valid = 1'b0;
    endtask

    task automatic wait_commit();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (duty_load) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("commit_timeout", 32'(ok), 1);
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("tick_timeout", 32'(ok), 1);
    endtask

    task automatic check_duties(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_duty0"}, 32'(duty_0), e0);
        check({tag, "_duty1"}, 32'(duty_1), e1);
        check({tag, "_duty2"}, 32'(duty_2), e2);
    endtask

    initial begin
        bit seen_load;

        vecs[0] = '{1'b1, 100, 0, 0,     75500, 75000, 75000};
        vecs[1] = '{1'b0, 0, 0, 0,       76000, 75000, 75000};
        vecs[2] = '{1'b0, 0, 0, 0,       76500, 75000, 75000};
        vecs[3] = '{1'b0, 0, 0, 0,       76600, 75000, 75000};
        vecs[4] = '{1'b0, 0, 0, 0,       76600, 75000, 75000};
        vecs[5] = '{1'b1, 0, 0, 10,      76100, 75000, 75160};
        vecs[6] = '{1'b1, 0, 0, -5,      75600, 75000, 74920};
        vecs[7] = '{1'b0, 0, 0, 0,       75100, 75000, 74920};
        vecs[8] = '{1'b0, 0, 0, 0,       75000, 75000, 74920};
        vecs[9] = '{1'b1, 2047, 0, 0,    75500, 75000, 75000};

        reset         = 1'b1;
        lags_in       = '0;
        lags_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_duties("reset", 75000, 75000, 75000);
        check("reset_load",  32'(duty_load),   0);
        check("reset_tick",  32'(period_tick), 0);
        check("reset_busy",  32'(busy),        0);
        check("reset_stale", 32'(stale),       0);
        reset = 1'b0;

        // Per-frame tracking vectors
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].send) send(vecs[i].l0, vecs[i].l1, vecs[i].l2);
            wait_commit();
            check_duties($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
        end

        // Lower clamp on ch1: 500 per frame down to 50000
        send(0, -2048, 0);
        for (int k = 1; k <= 50; k++) begin
            wait_commit();
            check($sformatf("clamp_f%0d_duty1", k), 32'(duty_1), 32'(75000 - 500 * k));
        end
        send(0, -2048, 0);
        wait_commit();
        check("clamp_hold_duty1", 32'(duty_1), 50000);
        check("clamp_hold_stale", 32'(stale),  0);

        // Overwrite: latest triplet in the frame wins
        send(0, 0, 10);
        send(0, 0, 20);
        wait_commit();
        check_duties("overwrite", 75000, 50500, 75320);

        // Valid coincident with period_tick, and commit latency
        wait_tick();
        check("lat_busy_T0", 32'(busy), 0);
        send(0, 0, -20);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            check($sformatf("lat_busy_T%0d", k), 32'(busy), 1);
            check($sformatf("lat_load_T%0d", k), 32'(duty_load), (k == 5) ? 1 : 0);
            if (k == 4) check_duties("lat_pre", 75000, 50500, 75320);
        end
        check_duties("lat_commit", 75000, 51000, 74820);
        @(negedge clk);
        check("lat_busy_T6", 32'(busy),      0);
        check("lat_load_T6", 32'(duty_load), 0);

        // Timeout: reach 76600, then starve for 50 frames
        send(100, 0, 0);
        for (int c = 1; c <= 54; c++) begin
            wait_commit();
            if (c == 4)  check("to_c4_duty0", 32'(duty_0), 76600);
            if (c == 50) check("to_c50_stale", 32'(stale), 0);
            if (c == 51) begin
                check("to_c51_stale", 32'(stale),  1);
                check("to_c51_duty0", 32'(duty_0), 76100);
            end
            if (c == 54) begin
                check("to_c54_stale", 32'(stale),  1);
                check("to_c54_duty0", 32'(duty_0), 75000);
            end
        end
        send(0, 0, 100);
        check("to_clear_stale", 32'(stale), 0);
        wait_commit();
        check("post_to_duty2_a", 32'(duty_2), 75500);
        wait_commit();
        check("post_to_duty2_b", 32'(duty_2), 76000);

        // Asynchronous reset in CALC1
        wait_tick();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_duties("midrst", 75000, 75000, 75000);
        check("midrst_busy",  32'(busy),      0);
        check("midrst_load",  32'(duty_load), 0);
        check("midrst_stale", 32'(stale),     0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_load |= duty_load;
        end
        check("midrst_no_load", 32'(seen_load), 0);
        send(0, 50, 0);
        wait_commit();
        check_duties("after_rst", 75000, 75500, 75000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
